// File: rtl/period_meter_pkg.sv
// period_meter_pkg
// Shared definitions for the period meter: FSM state encoding and default
// sizing constants.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/period_meter_sync_edge.sv
// sync_edge
// Brings an asynchronous level into the clk_in domain with a two-flop
// synchronizer, then compares it against one history flop to produce
// single-cycle edge flags. Rise and fall take the same path, so both flags
// lag the input change by the same 2-3 cycles.
//
// Ports
//   clk_in  in   system clock
//   rst     in   synchronous active-high reset, clears all three flops
//   i_sig   in   asynchronous input level
//   o_sync  out  synchronized level
//   o_rise  out  one-cycle flag, synchronized level went 0 -> 1
//   o_fall  out  one-cycle flag, synchronized level went 1 -> 0
module sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic i_sig,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise =  r_sync & ~r_hist;
    assign o_fall = ~r_sync &  r_hist;

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures the rising-to-rising period and the rising-to-falling high time
// of a slow asynchronous square wave, in clk_in cycles. Intervals longer
// than TIMEOUT cycles produce a timeout pulse instead of a result.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | disabled, counters cleared
//   ST_ARM     | waiting for the first rise; counter guards against a dead input
//   ST_MEASURE | counting since the last rise; each new rise yields a result
//
// Ports
//   clk_in     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   asynchronous square wave to measure
//   en         in   level-sensitive enable; low forces IDLE
//   period     out  last rising-to-rising interval
//   high_time  out  last rising-to-falling interval
//   valid      out  one-cycle pulse, period/high_time updated this cycle
//   timeout    out  one-cycle pulse, no qualifying edge within TIMEOUT
//   busy       out  high in ARM or MEASURE
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic             r_fall_seen;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_timeout;

    logic w_sync;
    logic w_rise;
    logic w_fall;
    logic w_fall_low;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_fall_low = w_fall & ~w_sync;

    // Counter value at a rise is the interval length because the counter is
    // loaded with 1 in the cycle after the starting rise. A rise always beats
    // the TIMEOUT compare, so an interval of exactly TIMEOUT still measures.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_high_cnt  <= '0;
            r_fall_seen <= 1'b0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (!en) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_high_cnt  <= '0;
                r_fall_seen <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_state     <= ST_MEASURE;
                            r_cnt       <= CNT_ONE;
                            r_fall_seen <= 1'b0;
                        end else if (r_cnt == CNT_TO) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_fall_seen ? r_high_cnt : r_cnt;
                            r_valid     <= 1'b1;
                            r_cnt       <= CNT_ONE;
                            r_fall_seen <= 1'b0;
                        end else if (r_cnt == CNT_TO) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_ARM;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                            if (w_fall_low && !r_fall_seen) begin
                                r_high_cnt  <= r_cnt;
                                r_fall_seen <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign busy      = (r_state == ST_ARM) || (r_state == ST_MEASURE);

endmodule
